// File: rtl/fifo_arb_pkg.sv
// Shared state encoding, default sizing and credit-width helper for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_DEPTH     = 32;
    localparam int DEF_BURST_MAX = 4;
`ifdef FIFO_ARB_WATCHDOG_EN
    localparam int DEF_WDOG_CYC  = 16;
`endif

    // Credit counter must represent 0..depth inclusive.
    function automatic int credit_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr, wrapping at NUM_REQ.
module fifo_arb_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
            if (!any && req[cand]) begin
                any          = 1'b1;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter for a shared FIFO write port with credit-based flow control.
// Define FIFO_ARB_WATCHDOG_EN to abort bursts stalled for WDOG_CYC cycles and raise wdog_err.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_REQ   = 2,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int BURST_MAX = DEF_BURST_MAX
`ifdef FIFO_ARB_WATCHDOG_EN
    ,
    parameter int WDOG_CYC  = DEF_WDOG_CYC
`endif
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           gnt,
    input  logic                         rd_pulse,
    output logic                         write_en,
    output logic [DATA_W-1:0]            data_in,
    output logic [$clog2(NUM_REQ)-1:0]   owner_id,
    output logic [credit_w(DEPTH)-1:0]   credits,
    output logic                         wdog_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = credit_w(DEPTH);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] FULL_CREDITS = CW'(DEPTH);

    arb_state_t           state, state_nx;
    logic [NUM_REQ-1:0]   gnt_nx;
    logic [IW-1:0]        owner_nx;
    logic [IW-1:0]        rr_ptr, rr_nx;
    logic [BW-1:0]        beat_cnt, beat_nx;
    logic [CW-1:0]        credits_nx;
    logic                 write_en_nx;
    logic [DATA_W-1:0]    data_nx;
    logic [DATA_W-1:0]    owner_data;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;
    logic                 accept;
    logic                 give_back;
    logic                 burst_end;
    logic                 stall_abort;

    fifo_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IW)
    ) u_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign owner_data = req_data[32'(owner_id) * DATA_W +: DATA_W];
    assign accept     = (state == GRANT) && req[owner_id] && gnt[owner_id] && (credits != '0);
    // A returned credit when already full has no slot to free, so it is dropped.
    assign give_back  = rd_pulse && (credits != FULL_CREDITS);

`ifdef FIFO_ARB_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYC + 1);

    logic [WW-1:0] stall_cnt, stall_nx;
    logic          wdog_nx;

    always_comb begin
        stall_nx    = '0;
        stall_abort = 1'b0;
        wdog_nx     = wdog_err;
        if (state == GRANT && !accept) begin
            if (32'(stall_cnt) == WDOG_CYC - 1) begin
                stall_abort = 1'b1;
                wdog_nx     = 1'b1;
            end else begin
                stall_nx = stall_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            wdog_err  <= 1'b0;
        end else begin
            stall_cnt <= stall_nx;
            wdog_err  <= wdog_nx;
        end
    end
`else
    assign stall_abort = 1'b0;
    assign wdog_err    = 1'b0;
`endif

    always_comb begin
        state_nx    = state;
        gnt_nx      = gnt;
        owner_nx    = owner_id;
        rr_nx       = rr_ptr;
        beat_nx     = beat_cnt;
        write_en_nx = 1'b0;
        data_nx     = data_in;
        burst_end   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nx = GRANT;
                    gnt_nx   = pick_onehot;
                    owner_nx = pick_idx;
                    beat_nx  = '0;
                end
            end
            GRANT: begin
                if (accept) begin
                    write_en_nx = 1'b1;
                    data_nx     = owner_data;
                    beat_nx     = beat_cnt + 1'b1;
                end
                burst_end = !req[owner_id]
                          || (accept && (req_last[owner_id] || 32'(beat_cnt) == BURST_MAX - 1))
                          || stall_abort;
                if (burst_end) begin
                    state_nx = IDLE;
                    gnt_nx   = '0;
                    beat_nx  = '0;
                    rr_nx    = (32'(owner_id) == NUM_REQ - 1) ? '0 : owner_id + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        credits_nx = credits;
        case ({accept, give_back})
            2'b10:   credits_nx = credits - 1'b1;
            2'b01:   credits_nx = credits + 1'b1;
            default: credits_nx = credits;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            gnt      <= '0;
            owner_id <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            write_en <= 1'b0;
            data_in  <= '0;
            credits  <= FULL_CREDITS;
        end else begin
            state    <= state_nx;
            gnt      <= gnt_nx;
            owner_id <= owner_nx;
            rr_ptr   <= rr_nx;
            beat_cnt <= beat_nx;
            write_en <= write_en_nx;
            data_in  <= data_nx;
            credits  <= credits_nx;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: a cycle model predicts grants/credits and queues expected writes.
module tb_fifo_write_arbiter;

    localparam int DATA_W    = 8;
    localparam int NUM_REQ   = 2;
    localparam int DEPTH     = 32;
    localparam int BURST_MAX = 4;
`ifdef FIFO_ARB_WATCHDOG_EN
    localparam int WDOG_CYC  = 16;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  gnt;
    logic        rd_pulse;
    logic        write_en;
    logic [7:0]  data_in;
    logic [0:0]  owner_id;
    logic [5:0]  credits;
    logic        wdog_err;

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .DATA_W    (DATA_W),
        .NUM_REQ   (NUM_REQ),
        .DEPTH     (DEPTH),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .gnt      (gnt),
        .rd_pulse (rd_pulse),
        .write_en (write_en),
        .data_in  (data_in),
        .owner_id (owner_id),
        .credits  (credits),
        .wdog_err (wdog_err)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } beat_t;

    beat_t      pq0[$];
    beat_t      pq1[$];
    logic [7:0] sb[$];

    bit         m_grant;
    int         m_owner, m_rr, m_beat, m_cred, m_stall;
    logic [1:0] m_gnt;
    bit         m_wdog;

    int vectors, miscompares, wr_count;

    task automatic drive();
        beat_t b0, b1;
        b0 = '0;
        b1 = '0;
        if (pq0.size() > 0) b0 = pq0[0];
        if (pq1.size() > 0) b1 = pq1[0];
        req      = {pq1.size() > 0, pq0.size() > 0};
        req_data = {b1.d, b0.d};
        req_last = {b1.last, b0.last};
    endtask

    task automatic model_reset();
        m_grant = 0; m_owner = 0; m_rr = 0; m_beat = 0;
        m_cred = DEPTH; m_stall = 0; m_gnt = 2'b00; m_wdog = 0;
        sb.delete();
        wr_count = 0;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        rd_pulse = 1'b0;
        pq0.delete();
        pq1.delete();
        drive();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Predict one clock edge from the model, apply it, then compare the DUT.
    task automatic step();
        bit         acc, bend, found, hl;
        int         o, n_owner, n_rr, n_beat, n_cred, n_stall;
        bit         n_grant, n_wdog;
        logic [1:0] n_gnt;
        logic [7:0] hd, exp_d;
        beat_t      b;
        drive();
        acc = 0; bend = 0; found = 0; hl = 0; hd = '0;
        o = m_owner;
        n_grant = m_grant; n_owner = m_owner; n_rr = m_rr; n_beat = m_beat;
        n_cred = m_cred; n_stall = m_stall; n_gnt = m_gnt; n_wdog = m_wdog;
        if (!m_grant) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int c;
                c = (m_rr + k) % NUM_REQ;
                if (!found && req[c]) begin
                    found = 1;
                    n_owner = c;
                end
            end
            if (found) begin
                n_grant = 1; n_gnt = 2'b00; n_gnt[n_owner] = 1'b1; n_beat = 0; n_stall = 0;
            end
        end else begin
            acc = req[o] && m_gnt[o] && (m_cred > 0);
            if (acc) begin
                b  = (o == 0) ? pq0[0] : pq1[0];
                hd = b.d;
                hl = b.last;
                sb.push_back(hd);
                n_beat  = m_beat + 1;
                n_stall = 0;
            end else begin
                n_stall = m_stall + 1;
            end
            bend = !req[o] || (acc && (hl || n_beat == BURST_MAX));
`ifdef FIFO_ARB_WATCHDOG_EN
            if (!acc && n_stall == WDOG_CYC) begin
                bend   = 1;
                n_wdog = 1;
            end
`endif
            if (bend) begin
                n_grant = 0; n_gnt = 2'b00; n_beat = 0; n_stall = 0;
                n_rr = (o + 1) % NUM_REQ;
            end
        end
        if (acc && !(rd_pulse && m_cred < DEPTH)) n_cred = m_cred - 1;
        else if (!acc && rd_pulse && m_cred < DEPTH) n_cred = m_cred + 1;

        @(posedge clk);
        #1;
        m_grant = n_grant; m_owner = n_owner; m_rr = n_rr; m_beat = n_beat;
        m_cred = n_cred; m_stall = n_stall; m_gnt = n_gnt; m_wdog = n_wdog;
        if (acc) begin
            if (o == 0) void'(pq0.pop_front());
            else        void'(pq1.pop_front());
        end

        if (write_en === 1'b1) begin
            wr_count++;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write t=%0t data_in=%h, no write expected", $time, data_in);
            end else begin
                exp_d = sb.pop_front();
                if (data_in !== exp_d) begin
                    miscompares++;
                    $display("FAIL write_data t=%0t got=%h exp=%h", $time, data_in, exp_d);
                end
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL missing_write t=%0t write_en=%b exp=1 data=%h", $time, write_en, sb[0]);
            sb.delete();
        end
        vectors++;
        if (gnt !== m_gnt) begin
            miscompares++;
            $display("FAIL gnt t=%0t got=%b exp=%b", $time, gnt, m_gnt);
        end
        vectors++;
        if (owner_id !== 1'(m_owner)) begin
            miscompares++;
            $display("FAIL owner_id t=%0t got=%0d exp=%0d", $time, owner_id, m_owner);
        end
        vectors++;
        if (credits !== 6'(m_cred)) begin
            miscompares++;
            $display("FAIL credits t=%0t got=%0d exp=%0d", $time, credits, m_cred);
        end
        vectors++;
        if (wdog_err !== m_wdog) begin
            miscompares++;
            $display("FAIL wdog_err t=%0t got=%b exp=%b", $time, wdog_err, m_wdog);
        end
        drive();
    endtask

    task automatic test_reset();
        do_reset();
        vectors += 6;
        if (gnt !== 2'b00)     begin miscompares++; $display("FAIL rst_gnt got=%b exp=00", gnt); end
        if (write_en !== 1'b0) begin miscompares++; $display("FAIL rst_write_en got=%b exp=0", write_en); end
        if (data_in !== 8'h00) begin miscompares++; $display("FAIL rst_data_in got=%h exp=00", data_in); end
        if (owner_id !== 1'b0) begin miscompares++; $display("FAIL rst_owner_id got=%0d exp=0", owner_id); end
        if (credits !== 6'd32) begin miscompares++; $display("FAIL rst_credits got=%0d exp=32", credits); end
        if (wdog_err !== 1'b0) begin miscompares++; $display("FAIL rst_wdog_err got=%b exp=0", wdog_err); end
    endtask

    task automatic test_single_burst();
        logic [5:0] we_h, g_h;
        do_reset();
        pq0.push_back('{8'hA1, 1'b0});
        pq0.push_back('{8'hA2, 1'b0});
        pq0.push_back('{8'hA3, 1'b1});
        for (int i = 0; i < 6; i++) begin
            step();
            we_h[i] = write_en;
            g_h[i]  = gnt[0];
        end
        vectors += 3;
        if (we_h !== 6'b001110) begin miscompares++; $display("FAIL single_we_pattern got=%b exp=001110", we_h); end
        if (g_h !== 6'b000111)  begin miscompares++; $display("FAIL single_gnt_pattern got=%b exp=000111", g_h); end
        if (credits !== 6'd29)  begin miscompares++; $display("FAIL single_credits got=%0d exp=29", credits); end
    endtask

    task automatic test_round_robin();
        int         own_q[$];
        logic [1:0] prev;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            pq0.push_back('{8'(8'h10 + k), 1'b0});
            pq1.push_back('{8'(8'h80 + k), 1'b0});
        end
        prev = 2'b00;
        for (int i = 0; i < 30 && own_q.size() < 3; i++) begin
            step();
            if (gnt != 2'b00 && prev == 2'b00) own_q.push_back(int'(owner_id));
            prev = gnt;
        end
        vectors++;
        if (own_q.size() != 3) begin
            miscompares++;
            $display("FAIL rr_grant_count got=%0d exp=3", own_q.size());
        end else begin
            vectors += 2;
            if (own_q[0] != 0 || own_q[2] != 0) begin
                miscompares++;
                $display("FAIL rr_owner_even got=%0d,%0d exp=0,0", own_q[0], own_q[2]);
            end
            if (own_q[1] != 1) begin
                miscompares++;
                $display("FAIL rr_owner_odd got=%0d exp=1", own_q[1]);
            end
        end
        vectors++;
        if (wr_count != 8) begin miscompares++; $display("FAIL rr_write_count got=%0d exp=8", wr_count); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int k = 0; k < 40; k++) pq0.push_back('{8'(k), 1'b0});
        for (int i = 0; i < 100 && wr_count < 32; i++) step();
        repeat (6) step();
        vectors += 3;
        if (wr_count != 32)    begin miscompares++; $display("FAIL fill_writes got=%0d exp=32", wr_count); end
        if (credits !== 6'd0)  begin miscompares++; $display("FAIL fill_credits got=%0d exp=0", credits); end
        if (gnt !== 2'b01)     begin miscompares++; $display("FAIL fill_gnt_held got=%b exp=01", gnt); end
        rd_pulse = 1'b1;
        step();
        rd_pulse = 1'b0;
        repeat (4) step();
        vectors += 2;
        if (wr_count != 33)    begin miscompares++; $display("FAIL refill_writes got=%0d exp=33", wr_count); end
        if (credits !== 6'd0)  begin miscompares++; $display("FAIL refill_credits got=%0d exp=0", credits); end
    endtask

    task automatic test_credit_tie();
        do_reset();
        rd_pulse = 1'b1;
        step();
        rd_pulse = 1'b0;
        vectors++;
        if (credits !== 6'd32) begin miscompares++; $display("FAIL credit_ceiling got=%0d exp=32", credits); end
        for (int k = 0; k < 40; k++) pq0.push_back('{8'(8'h40 + k), 1'b0});
        for (int i = 0; i < 200 && m_cred != 5; i++) step();
        for (int i = 0; i < 10 && !(m_grant && req[m_owner] && m_cred > 0); i++) step();
        rd_pulse = 1'b1;
        step();
        rd_pulse = 1'b0;
        vectors++;
        if (credits !== 6'd5) begin miscompares++; $display("FAIL credit_tie got=%0d exp=5", credits); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        pq0.push_back('{8'h5A, 1'b1});
        for (int k = 0; k < 4; k++) pq1.push_back('{8'(8'hC0 + k), 1'b0});
        for (int i = 0; i < 30 && wr_count < 3; i++) step();
        reset = 1'b0;
        #1;
        vectors += 6;
        if (gnt !== 2'b00)     begin miscompares++; $display("FAIL midrst_gnt got=%b exp=00", gnt); end
        if (write_en !== 1'b0) begin miscompares++; $display("FAIL midrst_write_en got=%b exp=0", write_en); end
        if (data_in !== 8'h00) begin miscompares++; $display("FAIL midrst_data_in got=%h exp=00", data_in); end
        if (owner_id !== 1'b0) begin miscompares++; $display("FAIL midrst_owner got=%0d exp=0", owner_id); end
        if (credits !== 6'd32) begin miscompares++; $display("FAIL midrst_credits got=%0d exp=32", credits); end
        if (wdog_err !== 1'b0) begin miscompares++; $display("FAIL midrst_wdog got=%b exp=0", wdog_err); end
        model_reset();
        pq0.push_back('{8'h5B, 1'b1});
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();
        vectors += 2;
        if (gnt !== 2'b01)     begin miscompares++; $display("FAIL midrst_regrant got=%b exp=01", gnt); end
        if (owner_id !== 1'b0) begin miscompares++; $display("FAIL midrst_reowner got=%0d exp=0", owner_id); end
        repeat (8) step();
    endtask

`ifdef FIFO_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        int held;
        do_reset();
        for (int k = 0; k < 40; k++) pq0.push_back('{8'(8'h60 + k), 1'b0});
        for (int i = 0; i < 100 && wr_count < 32; i++) step();
        held = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (gnt != 2'b00) held++;
            else if (held > 0) break;
        end
        vectors += 2;
        if (held != 16)        begin miscompares++; $display("FAIL wdog_hold_cycles got=%0d exp=16", held); end
        if (wdog_err !== 1'b1) begin miscompares++; $display("FAIL wdog_set got=%b exp=1", wdog_err); end
        repeat (20) step();
        vectors++;
        if (wdog_err !== 1'b1) begin miscompares++; $display("FAIL wdog_sticky got=%b exp=1", wdog_err); end
        do_reset();
        vectors++;
        if (wdog_err !== 1'b0) begin miscompares++; $display("FAIL wdog_clear got=%b exp=0", wdog_err); end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        wr_count    = 0;
        reset       = 1'b0;
        rd_pulse    = 1'b0;
        req         = '0;
        req_data    = '0;
        req_last    = '0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_fill();
        test_credit_tie();
        test_reset_mid_burst();
`ifdef FIFO_ARB_WATCHDOG_EN
        test_watchdog();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout t=%0t exp=finish before 200000", $time);
        $fatal(1, "simulation time limit reached");
    end

endmodule
